// File: rtl/board_io.sv
// board_io: conditions raw FPGA pins for the OPC system core.
//   - Two-flop synchronises and debounces N_SW switches and the user reset button.
//   - Sequences phy_reset_n and sys_select from the debounced button
//     (HOLD -> PHY_RST -> WAIT -> RUN).
//   - Drives N_LED LEDs through a shared PWM brightness control, gated off outside RUN.
// Ports:
//   clk, reset      : system clock, synchronous active-high reset
//   btn_reset_raw   : asynchronous reset button, 1 = pressed
//   sw_raw / sw     : asynchronous switch pins / debounced switch state
//   sw_change       : one-cycle pulse when any sw bit updates
//   led_in          : LED request from the core
//   led_level       : PWM brightness (0 = off, all-ones = fully on)
//   led_out         : LED pins
//   sys_select      : core run-enable
//   phy_reset_n     : external PHY reset, active low
module board_io #(
  parameter int unsigned N_SW                 = 8,
  parameter int unsigned N_LED                = 8,
  parameter int unsigned DEBOUNCE_CYCLES      = 400000,
  parameter int unsigned PHY_RESET_CYCLES     = 400,
  parameter int unsigned RESET_STRETCH_CYCLES = 40000,
  parameter int unsigned PWM_BITS             = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                btn_reset_raw,
  input  logic [N_SW-1:0]     sw_raw,
  output logic [N_SW-1:0]     sw,
  output logic                sw_change,
  input  logic [N_LED-1:0]    led_in,
  input  logic [PWM_BITS-1:0] led_level,
  output logic [N_LED-1:0]    led_out,
  output logic                sys_select,
  output logic                phy_reset_n
);

  // Switches and the button share one debounce array; the button is the top channel.
  localparam int unsigned NCh    = N_SW + 1;
  localparam int unsigned Dw     = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned CntMax = (PHY_RESET_CYCLES > RESET_STRETCH_CYCLES) ?
                                   PHY_RESET_CYCLES : RESET_STRETCH_CYCLES;
  localparam int unsigned Cw     = (CntMax > 1) ? $clog2(CntMax) : 1;

  typedef enum logic [1:0] {StHold, StPhyRst, StWait, StRun} state_e;

  logic [NCh-1:0]      sync1_q, sync2_q;
  logic [NCh-1:0]      deb_q, deb_d;
  logic [NCh-1:0]      upd;
  logic [Dw-1:0]       dcnt_q [NCh];
  logic [Dw-1:0]       dcnt_d [NCh];
  logic                btn_deb;
  logic                sw_change_q;

  state_e              state_q, state_d;
  logic [Cw-1:0]       cnt_q, cnt_d;
  logic                phy_reset_n_q, sys_select_q;

  logic [PWM_BITS-1:0] pwm_cnt_q;
  logic                pwm_on;
  logic [N_LED-1:0]    led_out_q;

  assign btn_deb = deb_q[N_SW];

  // Debounce: a channel updates only after DEBOUNCE_CYCLES consecutive differing cycles.
  always_comb begin
    deb_d = deb_q;
    upd   = '0;
    for (int i = 0; i < int'(NCh); i++) begin
      dcnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (dcnt_q[i] == Dw'(DEBOUNCE_CYCLES - 1)) begin
          deb_d[i] = sync2_q[i];
          upd[i]   = 1'b1;
        end else begin
          dcnt_d[i] = dcnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      deb_q       <= '0;
      sw_change_q <= 1'b0;
      for (int i = 0; i < int'(NCh); i++) dcnt_q[i] <= '0;
    end else begin
      sync1_q     <= {btn_reset_raw, sw_raw};
      sync2_q     <= sync1_q;
      deb_q       <= deb_d;
      sw_change_q <= |upd[N_SW-1:0];
      for (int i = 0; i < int'(NCh); i++) dcnt_q[i] <= dcnt_d[i];
    end
  end

  // Sequencer: a pressed button wins over any counter completion.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StHold:   if (!btn_deb) state_d = StPhyRst;
      StPhyRst: if (cnt_q == '0) state_d = StWait;
      StWait:   if (cnt_q == '0) state_d = StRun;
      StRun:    state_d = StRun;
      default:  state_d = StHold;
    endcase
    if (btn_deb) state_d = StHold;
  end

  // Shared down-counter, reloaded whenever the state changes.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      unique case (state_d)
        StPhyRst: cnt_d = Cw'(PHY_RESET_CYCLES - 1);
        StWait:   cnt_d = Cw'(RESET_STRETCH_CYCLES - 1);
        default:  cnt_d = '0;
      endcase
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  assign pwm_on = (pwm_cnt_q < led_level) || (led_level == {PWM_BITS{1'b1}});

  // Outputs are registered from the next state so they switch on the same edge as the FSM.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StHold;
      cnt_q         <= '0;
      phy_reset_n_q <= 1'b0;
      sys_select_q  <= 1'b0;
      pwm_cnt_q     <= '0;
      led_out_q     <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      phy_reset_n_q <= (state_d == StWait) || (state_d == StRun);
      sys_select_q  <= (state_d == StRun);
      pwm_cnt_q     <= pwm_cnt_q + 1'b1;
      led_out_q     <= (state_d == StRun) ? (led_in & {N_LED{pwm_on}}) : '0;
    end
  end

  assign sw          = deb_q[N_SW-1:0];
  assign sw_change   = sw_change_q;
  assign phy_reset_n = phy_reset_n_q;
  assign sys_select  = sys_select_q;
  assign led_out     = led_out_q;

endmodule

// File: tb/tb_board_io.sv
// Scoreboard bench for board_io with short debounce/sequence parameters.
// Stimulus pushes expected (edge, value) events; monitors pop on sw_change and on
// any change of {phy_reset_n, sys_select}.
module tb_board_io;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_reset_raw;
  logic [7:0] sw_raw;
  logic [7:0] sw;
  logic       sw_change;
  logic [7:0] led_in;
  logic [3:0] led_level;
  logic [7:0] led_out;
  logic       sys_select;
  logic       phy_reset_n;

  always #5 clk = ~clk;

  board_io #(
    .N_SW                 (8),
    .N_LED                (8),
    .DEBOUNCE_CYCLES      (4),
    .PHY_RESET_CYCLES     (8),
    .RESET_STRETCH_CYCLES (16),
    .PWM_BITS             (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .btn_reset_raw (btn_reset_raw),
    .sw_raw        (sw_raw),
    .sw            (sw),
    .sw_change     (sw_change),
    .led_in        (led_in),
    .led_level     (led_level),
    .led_out       (led_out),
    .sys_select    (sys_select),
    .phy_reset_n   (phy_reset_n)
  );

  typedef struct {
    int         t;
    logic [7:0] v;
  } ev_t;

  ev_t sw_q[$];
  ev_t seq_q[$];
  int  cyc    = 0;
  int  checks = 0;
  int  errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic ev_t mk(int t, logic [7:0] v);
    ev_t e;
    e.t = t;
    e.v = v;
    return e;
  endfunction

  task automatic check_eq(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(string name);
    checks++;
    errors++;
    $display("FAIL %s: unexpected event (cycle %0d)", name, cyc);
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Switch monitor: every sw_change pops one expected update.
  logic [7:0] sw_prev;
  always @(negedge clk) begin
    ev_t e;
    if (reset) begin
      sw_prev = sw;
    end else begin
      if (sw_change === 1'b1) begin
        if (sw_q.size() == 0) fail_now("sw_change_spurious");
        else begin
          e = sw_q.pop_front();
          check_eq("sw_time", cyc, e.t);
          check_eq("sw_value", {24'd0, sw}, {24'd0, e.v});
        end
      end else if (sw !== sw_prev) begin
        fail_now("sw_update_without_pulse");
      end
      sw_prev = sw;
    end
  end

  // Sequencer monitor: every change of {phy_reset_n, sys_select} pops one expected event.
  logic [1:0] seq_prev;
  always @(negedge clk) begin
    ev_t e;
    if (reset) begin
      seq_prev = {phy_reset_n, sys_select};
    end else begin
      if ({phy_reset_n, sys_select} !== seq_prev) begin
        if (seq_q.size() == 0) fail_now("seq_change_spurious");
        else begin
          e = seq_q.pop_front();
          check_eq("seq_time", cyc, e.t);
          check_eq("seq_value", {30'd0, phy_reset_n, sys_select}, {24'd0, e.v});
        end
      end
      seq_prev = {phy_reset_n, sys_select};
    end
  end

  // Counts LED samples over one PWM period: on = led_out equals led_in, bad = neither.
  task automatic pwm_measure(string name, logic [7:0] req, logic [3:0] lvl, int exp_on);
    int on  = 0;
    int bad = 0;
    led_in    = req;
    led_level = lvl;
    tick(2);
    for (int i = 0; i < 16; i++) begin
      tick(1);
      if (led_out === req) on++;
      else if (led_out !== 8'h00) bad++;
    end
    check_eq({name, "_on"}, on, exp_on);
    check_eq({name, "_bad"}, bad, 0);
  endtask

  initial begin
    int t;
    reset         = 1'b1;
    btn_reset_raw = 1'b0;
    sw_raw        = 8'h00;
    led_in        = 8'hFF;
    led_level     = 4'hF;

    // Power-up: everything low while reset is held, even with LEDs requested.
    tick(3);
    check_eq("rst_sw", {24'd0, sw}, 0);
    check_eq("rst_sw_change", {31'd0, sw_change}, 0);
    check_eq("rst_led_out", {24'd0, led_out}, 0);
    check_eq("rst_phy_reset_n", {31'd0, phy_reset_n}, 0);
    check_eq("rst_sys_select", {31'd0, sys_select}, 0);

    reset = 1'b0;
    t = cyc;
    seq_q.push_back(mk(t + 9, 8'h2));
    seq_q.push_back(mk(t + 25, 8'h3));
    tick(30);
    check_eq("powerup_run", {31'd0, sys_select}, 1);

    // Switch glitch of 3 cycles is discarded.
    sw_raw[3] = 1'b1;
    tick(3);
    sw_raw[3] = 1'b0;
    tick(10);
    check_eq("glitch_sw", {24'd0, sw}, 0);

    // Switch accepted, then released.
    t = cyc;
    sw_raw[3] = 1'b1;
    sw_q.push_back(mk(t + 6, 8'h08));
    tick(10);
    t = cyc;
    sw_raw[3] = 1'b0;
    sw_q.push_back(mk(t + 6, 8'h00));
    tick(10);

    // Two switches together: one update, one pulse.
    t = cyc;
    sw_raw = 8'h81;
    sw_q.push_back(mk(t + 6, 8'h81));
    tick(10);

    // PWM brightness.
    pwm_measure("pwm_l5", 8'hFF, 4'd5, 5);
    pwm_measure("pwm_l15", 8'hFF, 4'd15, 16);
    pwm_measure("pwm_l0", 8'hFF, 4'd0, 0);
    pwm_measure("pwm_half_l5", 8'h0F, 4'd5, 5);
    pwm_measure("pwm_half_l15", 8'h0F, 4'd15, 16);

    // Button pressed for 20 cycles in RUN, then released.
    led_in    = 8'hFF;
    led_level = 4'hF;
    tick(2);
    t = cyc;
    btn_reset_raw = 1'b1;
    seq_q.push_back(mk(t + 7, 8'h0));
    tick(6);
    check_eq("btn_led_before_hold", {24'd0, led_out}, 32'hFF);
    tick(1);
    check_eq("btn_led_in_hold", {24'd0, led_out}, 0);
    tick(13);
    btn_reset_raw = 1'b0;
    t = cyc;
    seq_q.push_back(mk(t + 15, 8'h2));
    seq_q.push_back(mk(t + 31, 8'h3));
    tick(40);

    // A 3-cycle press in RUN is ignored.
    btn_reset_raw = 1'b1;
    tick(3);
    btn_reset_raw = 1'b0;
    tick(15);
    check_eq("short_press_sel", {31'd0, sys_select}, 1);
    check_eq("short_press_led", {24'd0, led_out}, 32'hFF);

    // Reset abort mid PHY_RST, then a clean restart.
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(4);
    reset = 1'b1;
    tick(1);
    check_eq("mid_rst_phy", {31'd0, phy_reset_n}, 0);
    check_eq("mid_rst_sel", {31'd0, sys_select}, 0);
    check_eq("mid_rst_sw", {24'd0, sw}, 0);
    check_eq("mid_rst_led", {24'd0, led_out}, 0);
    reset = 1'b0;
    t = cyc;
    sw_q.push_back(mk(t + 6, 8'h81));
    seq_q.push_back(mk(t + 9, 8'h2));
    seq_q.push_back(mk(t + 25, 8'h3));
    tick(30);
    check_eq("restart_sel", {31'd0, sys_select}, 1);
    check_eq("restart_sw", {24'd0, sw}, 32'h81);

    check_eq("sw_queue_left", sw_q.size(), 0);
    check_eq("seq_queue_left", seq_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/board_io.md
# board_io

Board-level I/O conditioner between the raw FPGA pins and the OPC `system` core on the development boards. It synchronises and debounces N_SW switches and the user reset button, and sequences the external PHY reset and the core's `select` run-enable from the button. It drives N_LED LEDs through a shared PWM brightness control. It replaces the ad-hoc direct pin-to-core assignments in each board top level.

## Interface

- `N_SW`, 8, number of switch inputs
- `N_LED`, 8, number of LED outputs
- `DEBOUNCE_CYCLES`, 400000, consecutive stable cycles needed to accept a switch or button change (≥2)
- `PHY_RESET_CYCLES`, 400, cycles `phy_reset_n` is held low after the button is released (≥1)
- `RESET_STRETCH_CYCLES`, 40000, cycles between `phy_reset_n` rising and `sys_select` rising (≥1)
- `PWM_BITS`, 4, width of the PWM counter and brightness level

- `clk` in 1: single system clock; all logic is on its rising edge
- `reset` in 1: synchronous, active-high reset
- `btn_reset_raw` in 1: asynchronous user reset button, 1 = pressed
- `sw_raw` in N_SW: asynchronous switch pins
- `sw` out N_SW: debounced switch state
- `sw_change` out 1: one-cycle pulse when any `sw` bit updates
- `led_in` in N_LED: LED request from the core
- `led_level` in PWM_BITS: brightness; 0 = off, all-ones = fully on
- `led_out` out N_LED: LED pins
- `sys_select` out 1: core run-enable; 0 holds the core
- `phy_reset_n` out 1: external PHY reset, active low

## Operation

- **Synchronisers:** `btn_reset_raw` and every `sw_raw` bit pass through a two-flop synchroniser. No logic uses the raw pins directly.
- **Debounce (per channel, switches and button identical):**
  - Counter clears whenever the synchronised input equals the debounced value.
  - While they differ, the counter increments each cycle.
  - On the cycle the counter reaches DEBOUNCE_CYCLES−1 with the input still differing, the debounced bit takes the input value on the next edge and the counter clears.
  - A difference lasting fewer than DEBOUNCE_CYCLES cycles is discarded.
- **`sw_change`:** high for exactly one cycle, aligned with any `sw` bit update. If several bits update on the same cycle, it still pulses once.
- **Sequencer FSM:** states HOLD, PHY_RST, WAIT, RUN.
  - **HOLD:** `phy_reset_n`=0, `sys_select`=0. Moves to PHY_RST on the first edge at which the debounced button is 0.
  - **PHY_RST:** `phy_reset_n`=0. Counts PHY_RESET_CYCLES cycles, then moves to WAIT.
  - **WAIT:** `phy_reset_n`=1, `sys_select`=0. Counts RESET_STRETCH_CYCLES cycles, then moves to RUN.
  - **RUN:** `phy_reset_n`=1, `sys_select`=1.
  - A debounced button value of 1 forces HOLD from any state on the next edge. This takes priority over counter completion.
  - A single down-counter is shared between the states and reloads on each state entry.
- **LED PWM:**
  - Free-running PWM_BITS counter `pwm_cnt` that wraps to 0.
  - `led_out[i]` = `led_in[i]` & ((`pwm_cnt` < `led_level`) | (`led_level` == all-ones)), registered.
  - Duty is `led_level`/2^PWM_BITS, except all-ones, which is constant on.
  - `led_out` is forced to 0 whenever the state is not RUN.
- **Reset:** `reset` has priority over everything.
  - State goes to HOLD, all counters clear, and synchroniser flops clear.
  - `sw`=0, `sw_change`=0, `sys_select`=0, `phy_reset_n`=0, `led_out`=0.
  - Debounced button resets to 0.
  - Reset asserted mid-sequence or mid-debounce aborts it with no residual state.

## Timing

- All outputs are registered.
- Raw change to `sw` update: 2 + DEBOUNCE_CYCLES edges. `sw_change` appears on the same edge as the update.
- Button press to HOLD outputs (`sys_select`=0, `phy_reset_n`=0): 2 + DEBOUNCE_CYCLES + 1 edges.
- After `reset` deasserts with the button released (edge 1 = first edge with `reset` low):
  - Edge 1: HOLD→PHY_RST.
  - `phy_reset_n` rises at edge 1 + PHY_RESET_CYCLES.
  - `sys_select` rises at edge 1 + PHY_RESET_CYCLES + RESET_STRETCH_CYCLES.
- The PWM period is 2^PWM_BITS cycles. A change to `led_level` takes effect on the next edge, with no period alignment.

## Test plan

Parameters for all tests: DEBOUNCE_CYCLES=4, PHY_RESET_CYCLES=8, RESET_STRETCH_CYCLES=16, PWM_BITS=4, N_SW=N_LED=8.

- **Power-up:** release `reset` with the button at 0 → `phy_reset_n` rises at edge 9 and `sys_select` at edge 25. All outputs are 0 while `reset` is high.
- **Switch glitch:** `sw_raw[3]` pulses 1 for 3 cycles → `sw` stays 0x00 and there is no `sw_change`.
- **Switch accept:** hold `sw_raw[3]`=1 → `sw`=0x08 at edge 6 after the change, with a single `sw_change` pulse.
- **Simultaneous switches:** raise `sw_raw[0]` and `sw_raw[7]` together → `sw`=0x81 on one edge, with exactly one `sw_change` pulse.
- **Button in RUN:** press for 20 cycles → `sys_select`=0, `phy_reset_n`=0 and `led_out`=0 at edge 7 after the press. Release → the full sequence repeats. A 3-cycle press while in RUN is ignored.
- **PWM levels:** `led_in`=0xFF in RUN.
  - `led_level`=5 → each LED is high for exactly 5 of every 16 cycles.
  - `led_level`=15 → constant high.
  - `led_level`=0 → constant low.
  - `led_in`=0x0F → `led_out[7:4]` stay 0.
- **Reset mid-sequence:** assert `reset` during PHY_RST count 3 → the next edge gives reset values. Deassert → the sequence restarts from count 0, with `phy_reset_n` again rising at edge 9.
